// File: rtl/trb_pkg.sv
// Shared constants and types for the turbo decoded-bit stream packer.
package trb_pkg;
    localparam int ST_DEF         = 8;
    localparam int BUS_W_DEF      = 512;
    localparam int PKT_BYTES_DEF  = 128;
    localparam int WORD_BYTES_DEF = BUS_W_DEF / ST_DEF;
    localparam int IDX_W_DEF      = $clog2(WORD_BYTES_DEF);

    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} pack_state_e;

    typedef struct packed {
        logic [BUS_W_DEF-1:0] data;
        logic                 last;
        logic [IDX_W_DEF:0]   bytes;
        logic                 err;
    } trb_entry_t;
endpackage

// File: rtl/trb_pack_fifo2.sv
// Two-entry output FIFO with a registered head entry; push and pop may share a cycle.
module trb_pack_fifo2 #(
    parameter type T = trb_pkg::trb_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  T           i_din,
    input  logic       i_ready,
    output logic       o_valid,
    output T           o_dout,
    output logic [1:0] o_cnt
);
    T           r_head;
    T           r_tail;
    logic [1:0] r_cnt;
    logic       w_pop;

    assign w_pop   = (r_cnt != 2'd0) && i_ready;
    assign o_valid = (r_cnt != 2'd0);
    assign o_dout  = r_head;
    assign o_cnt   = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_din;
                    else               r_tail <= i_din;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_tail <= '0;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/trb_st_pack.sv
// Packs the 8-bit decoded-bit Avalon-ST stream into BUS_W-bit host words.
// Optional packet length policing is enabled by defining TRB_PACK_LEN_CHECK_EN.
module trb_st_pack
    import trb_pkg::*;
#(
    parameter int ST        = ST_DEF,
    parameter int BUS_W     = BUS_W_DEF,
    parameter int PKT_BYTES = PKT_BYTES_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ST-1:0]              st_data,
    input  logic                       st_valid,
    input  logic                       st_sop,
    input  logic                       st_eop,
    output logic                       st_ready,
    output logic [BUS_W-1:0]           word_data,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       word_last,
    output logic [$clog2(BUS_W/ST):0]  word_bytes,
    output logic                       word_err,
    output logic [15:0]                pkt_cnt,
    output logic [15:0]                drop_cnt
);
    localparam int WORD_BYTES = BUS_W / ST;
    localparam int IDX_W      = $clog2(WORD_BYTES);

    typedef struct packed {
        logic [BUS_W-1:0] data;
        logic             last;
        logic [IDX_W:0]   bytes;
        logic             err;
    } entry_t;

    pack_state_e      r_state, w_state_nxt;
    logic [BUS_W-1:0] r_acc, w_acc_nxt, w_acc_ins, w_byte0;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [IDX_W:0]   w_idx_inc;
    logic             r_pend, w_pend_nxt, r_live;
    logic             w_take, w_push, w_drop, w_pop, w_fifo_full;
    logic             w_err_eop, w_err_one, w_len_over;
    logic [1:0]       w_fifo_cnt;
    logic             w_head_valid;
    entry_t           w_ent, w_head;
    logic [15:0]      r_pkt_cnt, r_drop_cnt;

    // st_ready depends on registered state only, never on word_ready.
    assign w_fifo_full = (w_fifo_cnt == 2'd2);
    assign st_ready    = r_live && !w_fifo_full && !r_pend;
    assign w_take      = st_valid && st_ready;
    assign w_idx_inc   = {1'b0, r_idx} + (IDX_W+1)'(1);

`ifdef TRB_PACK_LEN_CHECK_EN
    localparam int LEN_W = $clog2(PKT_BYTES + 2) + 1;
    logic [LEN_W-1:0] r_len, w_len_inc;

    assign w_len_inc  = r_len + LEN_W'(1);
    assign w_err_eop  = (w_len_inc != LEN_W'(PKT_BYTES));
    assign w_err_one  = (PKT_BYTES != 1);
    assign w_len_over = (w_len_inc == LEN_W'(PKT_BYTES + 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_len <= '0;
        else if (w_take && st_sop)           r_len <= LEN_W'(1);
        else if (w_take && r_state == PKT)   r_len <= w_len_inc;
    end
`else
    assign w_err_eop  = 1'b0;
    assign w_err_one  = 1'b0;
    assign w_len_over = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_idx_nxt   = r_idx;
        w_pend_nxt  = r_pend;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        w_ent       = '0;
        w_byte0     = '0;
        w_byte0[ST-1:0] = st_data;
        w_acc_ins   = r_acc;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (r_idx == IDX_W'(b)) w_acc_ins[b*ST +: ST] = st_data;
        end

        if (r_pend) begin
            // Second word of an abort whose restarting byte also carried eop.
            if (!w_fifo_full) begin
                w_push      = 1'b1;
                w_ent       = '{data: r_acc, last: 1'b1, bytes: (IDX_W+1)'(1), err: w_err_one};
                w_acc_nxt   = '0;
                w_idx_nxt   = '0;
                w_pend_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        end else if (w_take) begin
            case (r_state)
                IDLE: begin
                    if (!st_sop) begin
                        w_drop = 1'b1;
                    end else if (st_eop) begin
                        w_push = 1'b1;
                        w_ent  = '{data: w_byte0, last: 1'b1, bytes: (IDX_W+1)'(1), err: w_err_one};
                    end else begin
                        w_acc_nxt   = w_byte0;
                        w_idx_nxt   = IDX_W'(1);
                        w_state_nxt = PKT;
                    end
                end
                default: begin
                    if (st_sop) begin
                        w_push     = 1'b1;
                        w_ent      = '{data: r_acc, last: 1'b1, bytes: {1'b0, r_idx}, err: 1'b1};
                        w_acc_nxt  = w_byte0;
                        w_idx_nxt  = IDX_W'(1);
                        w_pend_nxt = st_eop;
                    end else if (st_eop || w_len_over) begin
                        w_push      = 1'b1;
                        w_ent       = '{data: w_acc_ins, last: 1'b1, bytes: w_idx_inc,
                                        err: w_len_over | w_err_eop};
                        w_acc_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else if (r_idx == IDX_W'(WORD_BYTES - 1)) begin
                        w_push    = 1'b1;
                        w_ent     = '{data: w_acc_ins, last: 1'b0,
                                      bytes: (IDX_W+1)'(WORD_BYTES), err: 1'b0};
                        w_acc_nxt = '0;
                        w_idx_nxt = '0;
                    end else begin
                        w_acc_nxt = w_acc_ins;
                        w_idx_nxt = w_idx_inc[IDX_W-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_idx   <= w_idx_nxt;
            r_pend  <= w_pend_nxt;
            r_live  <= 1'b1;
        end
    end

    trb_pack_fifo2 #(.T(entry_t)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_ent),
        .i_ready (word_ready),
        .o_valid (w_head_valid),
        .o_dout  (w_head),
        .o_cnt   (w_fifo_cnt)
    );

    assign word_valid = w_head_valid;
    assign word_data  = w_head.data;
    assign word_last  = w_head.last;
    assign word_bytes = w_head.bytes;
    assign word_err   = w_head.err;
    assign w_pop      = w_head_valid && word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_pop && w_head.last)            r_pkt_cnt  <= r_pkt_cnt + 16'd1;
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_trb_st_pack.sv
// Bench for trb_st_pack: directed vector table, multi-cycle corner sequences and
// randomized traffic scored against a packet-level reference model.
module tb_trb_st_pack;
`ifdef TRB_PACK_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif
    localparam int PKT = 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   st_data = '0;
    logic         st_valid = 1'b0, st_sop = 1'b0, st_eop = 1'b0;
    logic         st_ready;
    logic [511:0] word_data;
    logic         word_valid, word_last, word_err;
    logic         word_ready = 1'b0;
    logic [6:0]   word_bytes;
    logic [15:0]  pkt_cnt, drop_cnt;

    trb_st_pack dut (
        .clk(clk), .rst_n(rst_n), .st_data(st_data), .st_valid(st_valid),
        .st_sop(st_sop), .st_eop(st_eop), .st_ready(st_ready),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .word_last(word_last), .word_bytes(word_bytes), .word_err(word_err),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        int           bytes;
        bit           last;
        bit           err;
    } word_t;

    int      n_checks = 0;
    int      n_err = 0;
    int      rdy_mode = 0;
    word_t   exp_q[$];
    word_t   hist[$];
    byte unsigned cur_q[$];
    bit      in_pkt = 0;
    int      pkt_len = 0;
    int      mdl_drops = 0;
    int      mdl_pkts = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: bytes of the current word are gathered in a queue and
    // cut into words by the packet framing rules.
    function automatic void emit_word(input bit last, input bit err);
        word_t w;
        w.data = '0;
        foreach (cur_q[i]) w.data[i*8 +: 8] = cur_q[i];
        w.bytes = cur_q.size();
        w.last = last;
        w.err = err;
        exp_q.push_back(w);
        cur_q.delete();
    endfunction

    function automatic void close_pkt(input bit err);
        emit_word(1'b1, err);
        in_pkt = 0;
        mdl_pkts++;
    endfunction

    function automatic void model_byte(input byte unsigned d, input bit s, input bit e);
        if (s) begin
            if (in_pkt) close_pkt(1'b1);
            cur_q.delete();
            cur_q.push_back(d);
            in_pkt = 1;
            pkt_len = 1;
            if (e) close_pkt(LEN_EN && pkt_len != PKT);
        end else if (!in_pkt) begin
            if (mdl_drops < 65535) mdl_drops++;
        end else begin
            cur_q.push_back(d);
            pkt_len++;
            if (e) close_pkt(LEN_EN && pkt_len != PKT);
            else if (LEN_EN && pkt_len == PKT + 1) close_pkt(1'b1);
            else if (cur_q.size() == 64) emit_word(1'b0, 1'b0);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0: word_ready = 1'b1;
            1: word_ready = 1'($urandom_range(0, 1));
            default: word_ready = 1'b0;
        endcase
    end

    // Output monitor: sampled on the falling edge, when all DUT outputs are settled.
    bit    held_v = 0;
    word_t held;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            held_v = 0;
        end else begin
            if (held_v && word_valid) begin
                n_checks++;
                if (word_data !== held.data || word_bytes !== 7'(held.bytes) ||
                    word_last !== held.last || word_err !== held.err) begin
                    n_err++;
                    $display("FAIL hold_stable: bytes %0d last %0b err %0b, held bytes %0d last %0b err %0b",
                             word_bytes, word_last, word_err, held.bytes, held.last, held.err);
                end
            end
            if (word_valid && word_ready) begin
                word_t e;
                word_t g;
                held_v = 0;
                g.data = word_data; g.bytes = int'(word_bytes); g.last = word_last; g.err = word_err;
                hist.push_back(g);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL word_extra: got bytes %0d last %0b, required no word", word_bytes, word_last);
                end else begin
                    e = exp_q.pop_front();
                    if (word_data !== e.data || word_bytes !== 7'(e.bytes) ||
                        word_last !== e.last || word_err !== e.err) begin
                        n_err++;
                        $display("FAIL word: got b=%0d l=%0b e=%0b d=%h required b=%0d l=%0b e=%0b d=%h",
                                 word_bytes, word_last, word_err, word_data, e.bytes, e.last, e.err, e.data);
                    end
                end
            end else if (word_valid) begin
                held_v = 1;
                held.data = word_data; held.bytes = int'(word_bytes);
                held.last = word_last; held.err = word_err;
            end else begin
                held_v = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit s, input bit e);
        int g = 0;
        st_data = d; st_sop = s; st_eop = e; st_valid = 1'b1;
        while (!st_ready && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) begin
            n_checks++;
            n_err++;
            $display("FAIL st_ready_timeout: got ready 0 for %0d cycles, required 1", g);
        end
        @(posedge clk);
        if (g < 1000) model_byte(d, s, e);
        @(negedge clk);
        st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit no_eop, input bit rnd);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : 8'(i);
            send_byte(d, i == 0, (i == n - 1) && !no_eop);
            if (rnd && $urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || word_valid) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        int orph; int nbytes; int abort_at; int words;
        int first_bytes; bit first_err; int last_bytes; bit last_err;
        int pkts; int drops;
    } vec_t;

    vec_t vt[9];
    int   p0, d0, n, o;
    bit   ab;

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 128,  0, 2, 64, 1'b0,   64, 1'b0,   1, 0};
        vt[1] = '{0,  70,  0, 2, 64, 1'b0,    6, LEN_EN, 1, 0};
        vt[2] = '{5,  20,  0, 1, 20, LEN_EN, 20, LEN_EN, 1, 5};
        vt[3] = '{0,   1,  0, 1,  1, LEN_EN,  1, LEN_EN, 1, 0};
        vt[4] = '{0,  25, 10, 2, 10, 1'b1,   25, LEN_EN, 2, 0};
        vt[5] = '{0,  64,  0, 1, 64, LEN_EN, 64, LEN_EN, 1, 0};
        vt[6] = '{0,  65,  0, 2, 64, 1'b0,    1, LEN_EN, 1, 0};
        vt[7] = '{0,   3, 64, 3, 64, 1'b0,    3, LEN_EN, 2, 0};
        vt[8] = '{0,   1,  5, 2,  5, 1'b1,    1, LEN_EN, 2, 0};

        repeat (3) @(negedge clk);
        chk("rst_st_ready", 64'(st_ready), 64'd0);
        chk("rst_word_valid", 64'(word_valid), 64'd0);
        chk("rst_word_data", 64'(|word_data), 64'd0);
        chk("rst_word_bytes", 64'(word_bytes), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_st_ready", 64'(st_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            hist.delete();
            p0 = int'(pkt_cnt);
            d0 = int'(drop_cnt);
            for (int k = 0; k < vt[i].orph; k++) send_byte(8'($urandom), 1'b0, 1'b0);
            if (vt[i].abort_at > 0) send_pkt(vt[i].abort_at, 1'b1, 1'b0);
            send_pkt(vt[i].nbytes, 1'b0, 1'b0);
            drain();
            chk($sformatf("v%0d_words", i), 64'(hist.size()), 64'(vt[i].words));
            chk($sformatf("v%0d_pkts", i), 64'(int'(pkt_cnt) - p0), 64'(vt[i].pkts));
            chk($sformatf("v%0d_drops", i), 64'(int'(drop_cnt) - d0), 64'(vt[i].drops));
            if (hist.size() > 0) begin
                chk($sformatf("v%0d_first_bytes", i), 64'(hist[0].bytes), 64'(vt[i].first_bytes));
                chk($sformatf("v%0d_first_err", i), 64'(hist[0].err), 64'(vt[i].first_err));
                chk($sformatf("v%0d_last_bytes", i), 64'(hist[$].bytes), 64'(vt[i].last_bytes));
                chk($sformatf("v%0d_last_flag", i), 64'(hist[$].last), 64'd1);
                chk($sformatf("v%0d_last_err", i), 64'(hist[$].err), 64'(vt[i].last_err));
            end
            if (i == 0 && hist.size() == 2) begin
                chk("v0_w0_last", 64'(hist[0].last), 64'd0);
                chk("v0_w0_byte63", 64'(hist[0].data[504 +: 8]), 64'h3F);
                chk("v0_w1_byte0", 64'(hist[1].data[7:0]), 64'h40);
                chk("v0_w1_byte63", 64'(hist[1].data[504 +: 8]), 64'h7F);
            end
            if (i == 1 && hist.size() == 2)
                chk("v1_upper_zero", 64'(|hist[1].data[511:48]), 64'd0);
            if (i == 4 && hist.size() == 2)
                chk("v4_restart_byte0", 64'(hist[1].data[7:0]), 64'h00);
        end

        // Host stalls for 300 cycles across three back-to-back packets.
        hist.delete();
        p0 = int'(pkt_cnt);
        rdy_mode = 2;
        fork
            begin
                for (int k = 0; k < 3; k++) send_pkt(128, 1'b0, 1'b0);
            end
            begin
                repeat (250) @(negedge clk);
                chk("stall_st_ready", 64'(st_ready), 64'd0);
                chk("stall_word_valid", 64'(word_valid), 64'd1);
                repeat (50) @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();
        chk("stall_words", 64'(hist.size()), 64'd6);
        chk("stall_pkts", 64'(int'(pkt_cnt) - p0), 64'd3);

        // Randomized traffic with random host back-pressure.
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(1, 200);
            o = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            ab = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < o; k++) send_byte(8'($urandom), 1'b0, 1'b0);
            send_pkt(n, ab, 1'b1);
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        rdy_mode = 0;
        send_pkt(10, 1'b0, 1'b1);
        drain();
        chk("rand_pkt_cnt", 64'(pkt_cnt), 64'(mdl_pkts[15:0]));
        chk("rand_drop_cnt", 64'(drop_cnt), 64'(mdl_drops));

        // Reset mid-packet with idx=30 and one word buffered.
        rdy_mode = 2;
        repeat (2) @(negedge clk);
        send_pkt(94, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("mid_buffered", 64'(word_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_word_valid", 64'(word_valid), 64'd0);
        chk("mid_rst_word_data", 64'(|word_data), 64'd0);
        chk("mid_rst_word_meta", 64'({word_last, word_err, word_bytes}), 64'd0);
        chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("mid_rst_st_ready", 64'(st_ready), 64'd0);
        exp_q.delete(); cur_q.delete(); hist.delete();
        in_pkt = 0; pkt_len = 0; mdl_drops = 0; mdl_pkts = 0;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_post_rst_ready", 64'(st_ready), 64'd1);
        send_pkt(70, 1'b0, 1'b0);
        drain();
        chk("mid_words", 64'(hist.size()), 64'd2);
        chk("mid_pkt_cnt", 64'(pkt_cnt), 64'd1);
        if (hist.size() == 2) chk("mid_last_bytes", 64'(hist[1].bytes), 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
